// File: rtl/lfsr_pkg.sv
// lfsr_pkg: constants shared by the LFSR stage and the sample FIFO.
//   RND_W          - width of the pseudo-random byte produced by the LFSR
//   FIFO_DEPTH_DEF - default number of FIFO entries
//   DROP_W         - width of the saturating drop counter
package lfsr_pkg;

  localparam int RND_W          = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DROP_W         = 8;

endpackage

// File: rtl/lfsr_sample_fifo_if.sv
// lfsr_sample_fifo_if: valid/ready stream that carries captured samples to the consumer.
//   out_valid - source has a head entry
//   out_ready - sink takes the head entry this cycle
//   out_data  - head entry, meaningful only while out_valid=1
//
// Handshake: a transfer happens on a rising clk edge where out_valid && out_ready.
// out_data is stable while out_valid=1 and no transfer has happened; out_ready
// is ignored while out_valid=0.
interface lfsr_sample_fifo_if;
  import lfsr_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [RND_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/lfsr_sample_fifo_btn_edge_sync.sv
// btn_edge_sync: turns the raw asynchronous capture button into a single-cycle pulse.
//   clk, rst  - clock, synchronous active-high reset
//   btn       - raw button level (asynchronous)
//   cap_pulse - one cycle high per accepted press
//
// The button passes through a two-flop synchroniser; a rising edge of the
// (optionally filtered) level is detected against a one-cycle delayed copy.
// cap_pulse is combinational from registers, so a press written on the
// FIFO's next edge lands 3 edges after the button rises.
//
// Build option CAP_DEBOUNCE_EN: the synchronised level must stay at a new
// value for DB_CYCLES consecutive cycles before the filtered level follows it.
module btn_edge_sync #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic cap_pulse
);

  logic sync_1;
  logic sync_2;
  logic level;
  logic level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

`ifdef CAP_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] db_cnt;
  logic             filt;

  // db_cnt counts consecutive cycles where sync_2 disagrees with filt; any
  // agreement restarts the count, so short glitches never reach the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (sync_2 == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
      db_cnt <= '0;
      filt   <= sync_2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = filt;
`else
  assign level = sync_2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign cap_pulse = level & ~level_d;

endmodule

// File: rtl/lfsr_sample_fifo.sv
// lfsr_sample_fifo: snapshots the LFSR byte on a capture press and queues it.
//   clk, rst  - clock, synchronous active-high reset
//   rnd_in    - pseudo-random byte from the LFSR stage
//   cap_btn   - raw asynchronous capture button
//   out_bus   - valid/ready stream of captured bytes (show-ahead head entry)
//   count     - occupancy 0..DEPTH
//   full      - count == DEPTH
//   drop_cnt  - captures lost to a full FIFO, saturating at all-ones
//
// Build option CAP_DEBOUNCE_EN enables the button debounce filter in
// btn_edge_sync (DB_CYCLES stable cycles).
module lfsr_sample_fifo
  import lfsr_pkg::*;
#(
  parameter  int DEPTH     = FIFO_DEPTH_DEF,
  localparam int PTR_W     = $clog2(DEPTH),
  parameter  int DB_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RND_W-1:0]         rnd_in,
  input  logic                     cap_btn,
  lfsr_sample_fifo_if.master       out_bus,
  output logic [PTR_W:0]           count,
  output logic                     full,
  output logic [DROP_W-1:0]        drop_cnt
);

  logic [RND_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             cap_pulse;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  btn_edge_sync #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .btn       (cap_btn),
    .cap_pulse (cap_pulse)
  );

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));

  // A pop in the same cycle frees the slot, so a capture at full is still
  // accepted; only a capture at full without a pop is dropped.
  assign pop  = !empty && out_bus.out_ready;
  assign push = cap_pulse && (!full || pop);
  assign drop = cap_pulse && full && !pop;

  // DEPTH is a power of two, so pointers wrap DEPTH-1 -> 0 by overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= rnd_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign out_bus.out_valid = !empty;
  assign out_bus.out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_lfsr_sample_fifo.sv
// tb_lfsr_sample_fifo: directed test of the capture FIFO with hand-computed expectations.
module tb_lfsr_sample_fifo;
  import lfsr_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
`ifdef CAP_DEBOUNCE_EN
  localparam int CAP_LAT = 3 + 16;
`else
  localparam int CAP_LAT = 3;
`endif

  logic             clk;
  logic             rst;
  logic [RND_W-1:0] rnd_in;
  logic             cap_btn;
  logic [PTR_W:0]   count;
  logic             full;
  logic [7:0]       drop_cnt;

  int checks;
  int errors;

  lfsr_sample_fifo_if bus ();

  lfsr_sample_fifo #(
    .DEPTH     (DEPTH),
    .DB_CYCLES (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rnd_in   (rnd_in),
    .cap_btn  (cap_btn),
    .out_bus  (bus.master),
    .count    (count),
    .full     (full),
    .drop_cnt (drop_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press, hold until the write edge, release and let the edge detector settle.
  task automatic capture(input logic [7:0] v);
    rnd_in  = v;
    cap_btn = 1'b1;
    step(CAP_LAT);
    cap_btn = 1'b0;
    step(CAP_LAT);
  endtask

  // Check the head entry then pop it.
  task automatic pop_expect(input string name, input logic [7:0] v);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== v) begin
      errors++;
      $display("FAIL %s: valid=%0b data=%02h, required valid=1 data=%02h",
               name, bus.out_valid, bus.out_data, v);
    end
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [PTR_W:0] c,
                             input logic f, input logic [7:0] d);
    checks++;
    if (count !== c || full !== f || drop_cnt !== d) begin
      errors++;
      $display("FAIL %s: count=%0d full=%0b drop=%0d, required count=%0d full=%0b drop=%0d",
               name, count, full, drop_cnt, c, f, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cap_btn = 1'b0; rnd_in = '0; bus.out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    check_state("reset_state", 0, 1'b0, 8'd0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: valid=%0b data=%02h, required valid=0 data=00",
               bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_single_capture();
    rnd_in  = 8'hA5;
    cap_btn = 1'b1;
    step(CAP_LAT - 1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: valid=%0b, required 0 before write edge", bus.out_valid);
    end
    step(1);
    cap_btn = 1'b0;
    check_state("single_count", 1, 1'b0, 8'd0);
    step(CAP_LAT);
    pop_expect("single_data", 8'hA5);
    check_state("single_after_pop", 0, 1'b0, 8'd0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: valid=%0b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_fill_drop();
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) capture(vals[i]);
    check_state("fill_full", 4, 1'b1, 8'd1);
    // out_ready while empty must not disturb anything after the drain
    for (int i = 0; i < 4; i++) pop_expect("fill_drain", vals[i]);
    bus.out_ready = 1'b1;
    step(2);
    bus.out_ready = 1'b0;
    check_state("fill_empty_ready", 0, 1'b0, 8'd1);
  endtask

  task automatic test_push_pop_full();
    for (int i = 1; i <= 4; i++) capture(8'(i));
    check_state("ppf_full", 4, 1'b1, 8'd1);
    rnd_in  = 8'h66;
    cap_btn = 1'b1;
    step(CAP_LAT - 1);
    bus.out_ready = 1'b1;   // pop lands on the same edge as the push
    step(1);
    bus.out_ready = 1'b0;
    cap_btn = 1'b0;
    step(CAP_LAT);
    check_state("ppf_no_drop", 4, 1'b1, 8'd1);
    pop_expect("ppf_drain", 8'h02);
    pop_expect("ppf_drain", 8'h03);
    pop_expect("ppf_drain", 8'h04);
    pop_expect("ppf_last", 8'h66);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      capture(8'(8'h30 + i * 7));
      pop_expect("wrap_data", 8'(8'h30 + i * 7));
    end
    check_state("wrap_empty", 0, 1'b0, 8'd1);
  endtask

  task automatic test_hold();
    rnd_in  = 8'h5A;
    cap_btn = 1'b1;
    step(50);
    cap_btn = 1'b0;
    step(CAP_LAT);
    check_state("hold_one_push", 1, 1'b0, 8'd1);
    pop_expect("hold_data", 8'h5A);
  endtask

  task automatic test_reset_mid();
    capture(8'h71);
    capture(8'h72);
    capture(8'h73);
    check_state("mid_three", 3, 1'b0, 8'd1);
    rst = 1'b1;
    step(1);
    check_state("mid_reset", 0, 1'b0, 8'd0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_out: valid=%0b data=%02h, required valid=0 data=00",
               bus.out_valid, bus.out_data);
    end
    rst = 1'b0;
    step(1);
  endtask

`ifdef CAP_DEBOUNCE_EN
  task automatic test_debounce();
    rnd_in  = 8'hC3;
    cap_btn = 1'b1;
    step(5);
    cap_btn = 1'b0;
    step(30);
    check_state("db_glitch", 0, 1'b0, 8'd0);
    cap_btn = 1'b1;
    step(CAP_LAT - 1);
    check_state("db_before", 0, 1'b0, 8'd0);
    step(1);
    check_state("db_write", 1, 1'b0, 8'd0);
    step(20 - CAP_LAT);
    cap_btn = 1'b0;
    step(CAP_LAT);
    pop_expect("db_data", 8'hC3);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_capture();
    test_fill_drop();
    test_push_pop_full();
    test_wrap();
    test_hold();
    test_reset_mid();
`ifdef CAP_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
